noc_rr_arbiter: RTL and testbench

NOC_RR_ARBITER -- requirements
Module: noc_rr_arbiter

---
 rtl/noc_arb_pkg.sv | 11 +
 rtl/noc_rr_arbiter_if.sv | 29 ++
 rtl/noc_rr_arbiter_rr_pick.sv | 36 +++
 rtl/noc_rr_arbiter.sv | 99 +++++++++
 tb/tb_noc_rr_arbiter.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/noc_arb_pkg.sv
// Shared constants for the NoC round-robin arbiter: flit type codes and
// default sizing.
package noc_arb_pkg;

    localparam int NPORTS_DEF = 5;
    localparam int LEN_W_DEF  = 12;
    localparam int FID_W_DEF  = 3;

    localparam logic [FID_W_DEF-1:0] FLIT_HEADER = 3'b001;

endpackage : noc_arb_pkg

// File: rtl/noc_rr_arbiter_if.sv
// Request/grant bundle between the NoC input ports (master) and the
// round-robin arbiter (slave).
interface noc_rr_arbiter_if
    import noc_arb_pkg::*;
#(
    parameter int NPORTS = NPORTS_DEF,
    parameter int LEN_W  = LEN_W_DEF,
    parameter int FID_W  = FID_W_DEF,
    localparam int IDX_W = $clog2(NPORTS)
);

    logic [NPORTS-1:0]       req;
    logic [NPORTS*FID_W-1:0] flit_id;
    logic [NPORTS*LEN_W-1:0] length;
    logic [NPORTS-1:0]       grant;
    logic [IDX_W-1:0]        grant_idx;
    logic                    timeout;

    modport master (
        output req, flit_id, length,
        input  grant, grant_idx, timeout
    );

    modport slave (
        input  req, flit_id, length,
        output grant, grant_idx, timeout
    );

endinterface : noc_rr_arbiter_if

// File: rtl/noc_rr_arbiter_rr_pick.sv
// Rotating priority search: the first requester after i_start (wrapping),
// with i_start itself examined last.
module rr_pick #(
    parameter int NPORTS = 5,
    localparam int IDX_W = $clog2(NPORTS)
) (
    input  logic [NPORTS-1:0] i_req,
    input  logic [IDX_W-1:0]  i_start,
    output logic              o_found,
    output logic [IDX_W-1:0]  o_idx
);

    int               w_c;
    logic [IDX_W-1:0] w_cand;

    // Walk from the farthest offset to the nearest so the nearest requester
    // is the last assignment and therefore wins.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_c     = 0;
        w_cand  = '0;
        for (int k = NPORTS; k >= 1; k--) begin
            w_c = int'(i_start) + k;
            if (w_c >= NPORTS) begin
                w_c = w_c - NPORTS;
            end
            w_cand = IDX_W'(w_c);
            if (i_req[w_cand]) begin
                o_found = 1'b1;
                o_idx   = w_cand;
            end
        end
    end

endmodule : rr_pick

// File: rtl/noc_rr_arbiter.sv
// Round-robin NoC output arbiter with per-port packet-length hold limits and
// a single shared hold counter; grant is registered (1-cycle latency).
module noc_rr_arbiter
    import noc_arb_pkg::*;
#(
    parameter int NPORTS = NPORTS_DEF,
    parameter int LEN_W  = LEN_W_DEF,
    parameter int FID_W  = FID_W_DEF,
    localparam int IDX_W = $clog2(NPORTS)
) (
    input  logic             clk,
    input  logic             rst,
    noc_rr_arbiter_if.slave  bus
);

    logic [NPORTS-1:0] r_grant;
    logic [IDX_W-1:0]  r_grant_idx;
    logic [IDX_W-1:0]  r_last;
    logic [LEN_W-1:0]  r_hold_cnt;
    logic              r_timeout;

    logic [LEN_W-1:0]  w_limit [NPORTS];
    logic              w_holder;
    logic [LEN_W-1:0]  w_lim;
    logic [LEN_W-1:0]  w_eff;
    logic              w_keep;
    logic              w_expire;
    logic [IDX_W-1:0]  w_ptr;
    logic              w_found;
    logic [IDX_W-1:0]  w_pick;

    // Limits are captured from header flits on every port, granted or not.
    genvar gi;
    generate
        for (gi = 0; gi < NPORTS; gi++) begin : g_limit
            logic [LEN_W-1:0] r_lim;
            logic             w_hdr;

            assign w_hdr = (bus.flit_id[gi*FID_W +: FID_W] == FID_W'(FLIT_HEADER));

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_lim <= '0;
                end else if (w_hdr) begin
                    r_lim <= bus.length[gi*LEN_W +: LEN_W];
                end
            end

            assign w_limit[gi] = r_lim;
        end
    endgenerate

    assign w_holder = |r_grant;
    assign w_lim    = w_limit[r_grant_idx];
    assign w_eff    = (w_lim == '0) ? LEN_W'(1) : w_lim;
    assign w_keep   = w_holder && bus.req[r_grant_idx] &&
                      (r_hold_cnt < (w_eff - LEN_W'(1)));
    // Still requesting but out of budget: the revocation is a timeout.
    assign w_expire = w_holder && bus.req[r_grant_idx] && !w_keep;
    assign w_ptr    = w_holder ? r_grant_idx : r_last;

    rr_pick #(
        .NPORTS (NPORTS)
    ) u_pick (
        .i_req   (bus.req),
        .i_start (w_ptr),
        .o_found (w_found),
        .o_idx   (w_pick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant     <= '0;
            r_grant_idx <= '0;
            r_hold_cnt  <= '0;
            r_last      <= IDX_W'(NPORTS - 1);
            r_timeout   <= 1'b0;
        end else begin
            r_timeout <= w_expire;
            if (w_keep) begin
                r_hold_cnt <= r_hold_cnt + LEN_W'(1);
            end else if (w_found) begin
                r_grant     <= NPORTS'(1) << w_pick;
                r_grant_idx <= w_pick;
                r_last      <= w_pick;
                r_hold_cnt  <= '0;
            end else begin
                r_grant     <= '0;
                r_grant_idx <= '0;
                r_hold_cnt  <= '0;
            end
        end
    end

    assign bus.grant     = r_grant;
    assign bus.grant_idx = r_grant_idx;
    assign bus.timeout   = r_timeout;

endmodule : noc_rr_arbiter

// File: tb/tb_noc_rr_arbiter.sv
// Directed self-checking bench for noc_rr_arbiter using immediate assertions.
module tb_noc_rr_arbiter;

    logic clk = 1'b0;
    logic rst;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    noc_rr_arbiter_if bus ();

    noc_rr_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int exp_grant, input int exp_idx,
                           input int exp_to);
        $display("step %-10s grant=%b idx=%0d timeout=%b", tag, bus.grant,
                 bus.grant_idx, bus.timeout);
        chk({tag, ".grant"}, int'(bus.grant), exp_grant);
        chk({tag, ".idx"}, int'(bus.grant_idx), exp_idx);
        chk({tag, ".timeout"}, int'(bus.timeout), exp_to);
        chk({tag, ".onehot0"}, int'($onehot0(bus.grant)), 1);
    endtask

    task automatic set_hdr(input int p, input int len);
        bus.flit_id[p*3 +: 3] = 3'b001;
        bus.length[p*12 +: 12] = 12'(len);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req = '0;
        bus.flit_id = '0;
        bus.length = '0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.req = '0;
        bus.flit_id = '0;
        bus.length = '0;
        repeat (2) tick();
        chk_out("reset", 0, 0, 0);

        // First arbitration after reset: port 0 highest priority, port 1 wins.
        rst = 1'b0;
        bus.req = 5'b00110;
        tick();
        chk_out("first", 5'b00010, 1, 0);

        // Port 2 length 4 vs port 3.
        do_reset();
        set_hdr(2, 4);
        bus.req = 5'b01100;
        tick();
        bus.flit_id = '0;
        chk_out("l4.c1", 5'b00100, 2, 0);
        tick(); chk_out("l4.c2", 5'b00100, 2, 0);
        tick(); chk_out("l4.c3", 5'b00100, 2, 0);
        tick(); chk_out("l4.c4", 5'b00100, 2, 0);
        tick(); chk_out("l4.to", 5'b01000, 3, 1);
        tick(); chk_out("l4.back", 5'b00100, 2, 1);

        // Port 0 alone with limit 3: re-granted with a fresh count.
        do_reset();
        set_hdr(0, 3);
        bus.req = 5'b00001;
        tick();
        bus.flit_id = '0;
        chk_out("solo.c1", 5'b00001, 0, 0);
        tick(); chk_out("solo.c2", 5'b00001, 0, 0);
        tick(); chk_out("solo.c3", 5'b00001, 0, 0);
        tick(); chk_out("solo.to", 5'b00001, 0, 1);
        tick(); chk_out("solo.r1", 5'b00001, 0, 0);
        tick(); chk_out("solo.r2", 5'b00001, 0, 0);
        tick(); chk_out("solo.to2", 5'b00001, 0, 1);

        // Limit 0 on port 4 behaves as 1.
        do_reset();
        set_hdr(4, 0);
        bus.req = 5'b10000;
        tick();
        bus.flit_id = '0;
        chk_out("lim0.c1", 5'b10000, 4, 0);
        bus.req = 5'b10001;
        tick();
        chk_out("lim0.nxt", 5'b00001, 0, 1);

        // Holder port 1 drops request; rotation picks port 3, no timeout.
        do_reset();
        set_hdr(1, 10);
        bus.req = 5'b00010;
        tick();
        bus.flit_id = '0;
        chk_out("drop.c1", 5'b00010, 1, 0);
        bus.req = 5'b01011;
        tick();
        chk_out("drop.c2", 5'b00010, 1, 0);
        bus.req = 5'b01001;
        tick();
        chk_out("drop.rot", 5'b01000, 3, 0);

        // Nobody requesting: idle, last_granted (3) kept so port 4 beats 0.
        bus.req = 5'b00000;
        tick();
        chk_out("idle", 0, 0, 0);
        bus.req = 5'b10001;
        tick();
        chk_out("idle.rot", 5'b10000, 4, 0);

        // Reset mid-grant on port 2.
        do_reset();
        set_hdr(2, 8);
        bus.req = 5'b00100;
        tick();
        bus.flit_id = '0;
        chk_out("rst.c1", 5'b00100, 2, 0);
        tick();
        chk_out("rst.c2", 5'b00100, 2, 0);
        rst = 1'b1;
        bus.req = 5'b00101;
        tick();
        chk_out("rst.drop", 0, 0, 0);
        rst = 1'b0;
        tick();
        chk_out("rst.arb", 5'b00001, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_noc_rr_arbiter
